// File: rtl/des_round_engine_if.sv
// Block-in / block-out handshake bundle for the iterative DES round engine.
// The engine takes the slave side; whoever feeds and drains blocks takes the master side.
interface des_round_engine_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] DATA_IN;
  logic        decrypt;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] DATA_OUT;
  logic        busy;

  modport slave (
    input  in_valid,
    input  DATA_IN,
    input  decrypt,
    input  out_ready,
    output in_ready,
    output out_valid,
    output DATA_OUT,
    output busy
  );

  modport master (
    output in_valid,
    output DATA_IN,
    output decrypt,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  DATA_OUT,
    input  busy
  );
endinterface

// File: rtl/des_round_engine.sv
// Iterative DES data path: IP on accept, one Feistel round per clock, FP on the last round.
// Round keys are read live from the key generator every round; nothing is stored here.
module des_round_engine (
  input  logic              clk,
  input  logic              rst_n,
  des_round_engine_if.slave bus,
  input  logic [47:0]       r_key1,
  input  logic [47:0]       r_key2,
  input  logic [47:0]       r_key3,
  input  logic [47:0]       r_key4,
  input  logic [47:0]       r_key5,
  input  logic [47:0]       r_key6,
  input  logic [47:0]       r_key7,
  input  logic [47:0]       r_key8,
  input  logic [47:0]       r_key9,
  input  logic [47:0]       r_key10,
  input  logic [47:0]       r_key11,
  input  logic [47:0]       r_key12,
  input  logic [47:0]       r_key13,
  input  logic [47:0]       r_key14,
  input  logic [47:0]       r_key15,
  input  logic [47:0]       r_key16
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  // Permutation tables list, for each output DES bit, the source DES bit number.
  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7
  };

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,
    39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,
    37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,
    35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,
    33, 1, 41,  9, 49, 17, 57, 25
  };

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,
     4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,
    12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,
    20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,
    28, 29, 30, 31, 32,  1
  };

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,
     1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,
    19, 13, 30,  6, 22, 11,  4, 25
  };

  // Each S-box is 64 nibbles, entry {row,col} = 0 in the top nibble.
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  function automatic logic [63:0] permIp(input logic [63:0] d);
    logic [63:0] o;
    for (int i = 0; i < 64; i++) o[63-i] = d[6'(64 - IP_T[i])];
    return o;
  endfunction

  function automatic logic [63:0] permFp(input logic [63:0] d);
    logic [63:0] o;
    for (int i = 0; i < 64; i++) o[63-i] = d[6'(64 - FP_T[i])];
    return o;
  endfunction

  function automatic logic [47:0] expandE(input logic [31:0] r);
    logic [47:0] o;
    for (int i = 0; i < 48; i++) o[47-i] = r[5'(32 - E_T[i])];
    return o;
  endfunction

  function automatic logic [31:0] permP(input logic [31:0] s);
    logic [31:0] o;
    for (int i = 0; i < 32; i++) o[31-i] = s[5'(32 - P_T[i])];
    return o;
  endfunction

  // Row comes from the outer two bits of each 6-bit group, column from the inner four.
  function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
    logic [47:0]  x;
    logic [5:0]   six;
    logic [255:0] sh;
    logic [31:0]  s;
    x = expandE(r) ^ k;
    s = '0;
    for (int j = 0; j < 8; j++) begin
      six = x[47 - 6*j -: 6];
      sh  = SBOX[j] << {six[5], six[0], six[4:1], 2'b00};
      s[31 - 4*j -: 4] = sh[255:252];
    end
    return permP(s);
  endfunction

  state_t      r_state;
  state_t      w_nextState;
  logic [3:0]  r_cnt;
  logic [31:0] r_left;
  logic [31:0] r_right;
  logic [63:0] r_dataOut;
  logic        r_decrypt;

  logic [47:0] w_keys [16];
  logic [3:0]  w_keyIdx;
  logic [47:0] w_roundKey;
  logic [31:0] w_rightNew;
  logic        w_inReady;
  logic        w_outValid;
  logic        w_busy;
  logic        w_accept;
  logic        w_lastRound;

  assign w_keys[0]  = r_key1;
  assign w_keys[1]  = r_key2;
  assign w_keys[2]  = r_key3;
  assign w_keys[3]  = r_key4;
  assign w_keys[4]  = r_key5;
  assign w_keys[5]  = r_key6;
  assign w_keys[6]  = r_key7;
  assign w_keys[7]  = r_key8;
  assign w_keys[8]  = r_key9;
  assign w_keys[9]  = r_key10;
  assign w_keys[10] = r_key11;
  assign w_keys[11] = r_key12;
  assign w_keys[12] = r_key13;
  assign w_keys[13] = r_key14;
  assign w_keys[14] = r_key15;
  assign w_keys[15] = r_key16;

  // Decryption is the same network walked with the key schedule reversed.
  assign w_keyIdx    = r_decrypt ? (4'd15 - r_cnt) : r_cnt;
  assign w_roundKey  = w_keys[w_keyIdx];
  assign w_rightNew  = r_left ^ feistel(r_right, w_roundKey);
  assign w_accept    = bus.in_valid && w_inReady;
  assign w_lastRound = (r_state == ROUND) && (r_cnt == 4'd15);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_inReady   = 1'b0;
    w_outValid  = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      IDLE: begin
        w_inReady = 1'b1;
        w_busy    = 1'b0;
        if (bus.in_valid) w_nextState = ROUND;
      end
      ROUND: begin
        if (r_cnt == 4'd15) w_nextState = DONE;
      end
      DONE: begin
        w_outValid = 1'b1;
        if (bus.out_ready) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // The last round writes FP of the swapped halves; DATA_OUT then holds until the next block ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= 4'd0;
      r_left    <= 32'd0;
      r_right   <= 32'd0;
      r_dataOut <= 64'd0;
      r_decrypt <= 1'b0;
    end else if (w_accept) begin
      {r_left, r_right} <= permIp(bus.DATA_IN);
      r_decrypt         <= bus.decrypt;
      r_cnt             <= 4'd0;
    end else if (r_state == ROUND) begin
      r_left  <= r_right;
      r_right <= w_rightNew;
      r_cnt   <= w_lastRound ? 4'd0 : r_cnt + 4'd1;
      if (w_lastRound) r_dataOut <= permFp({w_rightNew, r_right});
    end
  end

  assign bus.in_ready  = w_inReady;
  assign bus.out_valid = w_outValid;
  assign bus.busy      = w_busy;
  assign bus.DATA_OUT  = r_dataOut;

endmodule

// File: tb/tb_des_round_engine.sv
// Self-checking bench for des_round_engine: known-answer table, reset and backpressure
// sequences, and random back-to-back blocks scored against an independent DES model.
module tb_des_round_engine;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  des_round_engine_if busIf();
  logic [47:0] rk [16];

  des_round_engine dut (
    .clk(clk), .rst_n(rst_n), .bus(busIf),
    .r_key1(rk[0]),   .r_key2(rk[1]),   .r_key3(rk[2]),   .r_key4(rk[3]),
    .r_key5(rk[4]),   .r_key6(rk[5]),   .r_key7(rk[6]),   .r_key8(rk[7]),
    .r_key9(rk[8]),   .r_key10(rk[9]),  .r_key11(rk[10]), .r_key12(rk[11]),
    .r_key13(rk[12]), .r_key14(rk[13]), .r_key15(rk[14]), .r_key16(rk[15])
  );

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7
  };
  localparam int E_T [48] = '{
    32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1
  };
  localparam int P_T [32] = '{
    16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
    2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25
  };
  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
    10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
    14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4
  };
  localparam int PC2_T [48] = '{
    14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10, 23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SHIFT_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  // One 64-bit word per S-box row, column 0 in the top nibble.
  localparam logic [63:0] SROW [32] = '{
    64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
    64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
    64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
    64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
    64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
    64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
    64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
    64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
  };

  typedef struct { logic [63:0] data; int acceptEdge; } sbEntry_t;
  typedef struct { logic [63:0] key; logic [63:0] data; logic dec; logic [63:0] exp; } vec_t;

  sbEntry_t    sbQ [$];
  vec_t        vecs [6];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          acceptCount = 0;
  bit          monOn = 0;
  bit          inFlight = 0;
  logic        prevOv = 1'b0;
  logic        useTableExp = 1'b0;
  logic [63:0] tableExp = '0;

  // Key generator stand-in: PC1, per-round rotations, PC2.
  task automatic setKey(input logic [63:0] key);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] k;
    for (int i = 0; i < 56; i++) cd[55-i] = key[6'(64 - PC1_T[i])];
    c = cd[55:28];
    d = cd[27:0];
    for (int r = 0; r < 16; r++) begin
      for (int s = 0; s < SHIFT_T[r]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) k[47-i] = cd[6'(56 - PC2_T[i])];
      rk[r] = k;
    end
  endtask

  function automatic logic [31:0] tbF(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s, o;
    logic [5:0]  six;
    logic [63:0] rowv;
    int          col;
    for (int i = 0; i < 48; i++) x[47-i] = r[5'(32 - E_T[i])];
    x = x ^ k;
    for (int j = 0; j < 8; j++) begin
      six  = x[47 - 6*j -: 6];
      rowv = SROW[j*4 + int'({six[5], six[0]})];
      col  = int'(six[4:1]);
      s[31 - 4*j -: 4] = rowv[63 - 4*col -: 4];
    end
    for (int i = 0; i < 32; i++) o[31-i] = s[5'(32 - P_T[i])];
    return o;
  endfunction

  // Final permutation taken as the inverse of IP rather than from its own table.
  function automatic logic [63:0] tbDes(input logic [63:0] blk, input logic dec);
    logic [63:0] x, y;
    logic [31:0] l, r, t;
    for (int i = 0; i < 64; i++) x[63-i] = blk[6'(64 - IP_T[i])];
    l = x[63:32];
    r = x[31:0];
    for (int i = 0; i < 16; i++) begin
      t = r;
      r = l ^ tbF(r, dec ? rk[15-i] : rk[i]);
      l = t;
    end
    x = {r, l};
    for (int i = 0; i < 64; i++) y[6'(64 - IP_T[i])] = x[63-i];
    return y;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic reportTimeout(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: got timeout, want event", name);
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard: push on an observed accept, pop and compare on an observed transfer.
  always @(negedge clk) begin
    if (monOn) begin
      checkOutput("inReadyIdle", 64'(busIf.in_ready), 64'(!inFlight));
      checkOutput("busyFlight", 64'(busIf.busy), 64'(inFlight));
      if (busIf.out_valid && !prevOv) begin
        if (sbQ.size() == 0) checkOutput("spuriousOutValid", 64'(busIf.out_valid), 64'd0);
        else checkOutput("latency", 64'(cyc - sbQ[0].acceptEdge), 64'd16);
      end
      if (busIf.out_valid && busIf.out_ready) begin
        if (sbQ.size() == 0) checkOutput("spuriousXfer", 64'(busIf.out_valid), 64'd0);
        else begin
          sbEntry_t e;
          e = sbQ.pop_front();
          checkOutput("dataOut", busIf.DATA_OUT, e.data);
        end
        inFlight = 0;
      end
      if (busIf.in_valid && busIf.in_ready) begin
        sbEntry_t e;
        e.data = useTableExp ? tableExp : tbDes(busIf.DATA_IN, busIf.decrypt);
        e.acceptEdge = cyc + 1;
        sbQ.push_back(e);
        inFlight = 1;
        acceptCount++;
      end
    end
    prevOv = busIf.out_valid;
  end

  task automatic applyStimulus(input logic [63:0] data, input logic dec,
                               input logic useTbl, input logic [63:0] exp);
    int start;
    int n;
    @(posedge clk); #1;
    busIf.DATA_IN  = data;
    busIf.decrypt  = dec;
    useTableExp    = useTbl;
    tableExp       = exp;
    busIf.in_valid = 1'b1;
    start = acceptCount;
    for (n = 0; n < 100 && acceptCount == start; n++) @(posedge clk);
    #1 busIf.in_valid = 1'b0;
    if (acceptCount == start) reportTimeout("accept");
  endtask

  task automatic waitDrain();
    int n;
    for (n = 0; n < 300 && sbQ.size() != 0; n++) @(posedge clk);
    if (sbQ.size() != 0) reportTimeout("drain");
    #1;
  endtask

  task automatic checkQuiet(input string name);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput(name, 64'(busIf.out_valid), 64'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no finish, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int target;
    vecs[0] = '{64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0, 64'h85E813540F0AB405};
    vecs[1] = '{64'h133457799BBCDFF1, 64'h85E813540F0AB405, 1'b1, 64'h0123456789ABCDEF};
    vecs[2] = '{64'h0000000000000000, 64'h0000000000000000, 1'b0, 64'h8CA64DE9C1B123A7};
    vecs[3] = '{64'h0000000000000000, 64'h8CA64DE9C1B123A7, 1'b1, 64'h0000000000000000};
    vecs[4] = '{64'h0E329232EA6D0D73, 64'h8787878787878787, 1'b0, 64'h0000000000000000};
    vecs[5] = '{64'h0E329232EA6D0D73, 64'h0000000000000000, 1'b1, 64'h8787878787878787};

    rst_n = 1'b0;
    busIf.in_valid = 1'b0;
    busIf.DATA_IN = '0;
    busIf.decrypt = 1'b0;
    busIf.out_ready = 1'b1;
    setKey(64'h0);

    @(negedge clk);
    checkOutput("rstInReady", 64'(busIf.in_ready), 64'd1);
    checkOutput("rstOutValid", 64'(busIf.out_valid), 64'd0);
    checkOutput("rstBusy", 64'(busIf.busy), 64'd0);
    checkOutput("rstDataOut", busIf.DATA_OUT, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    monOn = 1;

    $display("[TB] known-answer table");
    for (int i = 0; i < 6; i++) begin
      setKey(vecs[i].key);
      applyStimulus(vecs[i].data, vecs[i].dec, 1'b1, vecs[i].exp);
      waitDrain();
    end

    $display("[TB] reset while idle");
    monOn = 0;
    rst_n = 1'b0;
    #1;
    checkOutput("idleRstDataOut", busIf.DATA_OUT, 64'd0);
    checkOutput("idleRstInReady", 64'(busIf.in_ready), 64'd1);
    checkOutput("idleRstBusy", 64'(busIf.busy), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    checkQuiet("idleRstQuiet");
    @(posedge clk); #1 monOn = 1;

    $display("[TB] output backpressure");
    setKey(64'h133457799BBCDFF1);
    busIf.out_ready = 1'b0;
    applyStimulus(64'h0123456789ABCDEF, 1'b0, 1'b1, 64'h85E813540F0AB405);
    for (n = 0; n < 60 && busIf.out_valid !== 1'b1; n++) @(negedge clk);
    if (busIf.out_valid !== 1'b1) reportTimeout("bpOutValid");
    busIf.DATA_IN  = 64'h85E813540F0AB405;
    busIf.decrypt  = 1'b1;
    useTableExp    = 1'b1;
    tableExp       = 64'h0123456789ABCDEF;
    busIf.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("bpHoldData", busIf.DATA_OUT, 64'h85E813540F0AB405);
      checkOutput("bpHoldValid", 64'(busIf.out_valid), 64'd1);
    end
    @(posedge clk); #1 busIf.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("bpOneCycleXfer", 64'(busIf.out_valid), 64'd0);
    checkOutput("bpAcceptNext", 64'(busIf.in_ready), 64'd1);
    @(posedge clk); #1 busIf.in_valid = 1'b0;
    waitDrain();

    $display("[TB] reset during round 7");
    applyStimulus(64'h0123456789ABCDEF, 1'b0, 1'b1, 64'h85E813540F0AB405);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("midBusyBefore", 64'(busIf.busy), 64'd1);
    monOn = 0;
    rst_n = 1'b0;
    #1;
    checkOutput("midRstDataOut", busIf.DATA_OUT, 64'd0);
    checkOutput("midRstInReady", 64'(busIf.in_ready), 64'd1);
    checkOutput("midRstOutValid", 64'(busIf.out_valid), 64'd0);
    checkOutput("midRstBusy", 64'(busIf.busy), 64'd0);
    sbQ.delete();
    inFlight = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    checkQuiet("midRstQuiet");
    @(posedge clk); #1 monOn = 1;

    $display("[TB] random back-to-back blocks");
    useTableExp = 1'b0;
    for (int kk = 0; kk < 2; kk++) begin
      setKey({$urandom, $urandom});
      target = acceptCount + 6;
      busIf.DATA_IN  = {$urandom, $urandom};
      busIf.decrypt  = 1'($urandom_range(0, 1));
      busIf.in_valid = 1'b1;
      for (n = 0; n < 2000 && acceptCount < target; n++) begin
        @(posedge clk); #1;
        busIf.DATA_IN   = {$urandom, $urandom};
        busIf.decrypt   = 1'($urandom_range(0, 1));
        busIf.out_ready = ($urandom_range(0, 3) != 0);
      end
      busIf.in_valid  = 1'b0;
      busIf.out_ready = 1'b1;
      if (acceptCount < target) reportTimeout("randomAccepts");
      waitDrain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
